// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl
//   Multi-digit common-anode 7-segment scan controller. A binary value captured
//   on `load` is converted to BCD one bit per clock (shift-add-3). The finished
//   result is then time-multiplexed across NUM_DIGITS digits, with leading-zero
//   blanking, per-digit decimal points, per-digit blink and an overflow dash.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   bin_data    unsigned binary value, captured when load=1 and busy=0
//   load        one-cycle strobe starting a conversion
//   busy        conversion in progress (loads ignored while high)
//   dp_mask     decimal point enable per digit, bit0 = ones digit (live)
//   blink_mask  blink enable per digit (live)
//   blank_lz    leading-zero blanking enable (live)
//   ovf         last loaded value does not fit in NUM_DIGITS decimal digits
//   fnd_data    active-low segments {dp,g,f,e,d,c,b,a}
//   fnd_com     active-low digit commons, one low at a time
module fnd_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned SCAN_HZ    = 1_000,
    parameter int unsigned BLINK_HZ   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     bin_data,
    input  logic                  load,
    output logic                  busy,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    input  logic                  blank_lz,
    output logic                  ovf,
    output logic [7:0]            fnd_data,
    output logic [NUM_DIGITS-1:0] fnd_com
);

    // Decimal digits needed to represent 2^width-1.
    function automatic int unsigned bcd_digits_for(input int unsigned width);
        longint unsigned v;
        int unsigned     n;
        v = (64'd1 << width) - 64'd1;
        n = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                n++;
                v = v / 64'd10;
            end
        end
        return (n == 0) ? 32'd1 : n;
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    localparam int unsigned BCD_DIGITS = bcd_digits_for(DATA_W);
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned EXT_DIGITS = (NUM_DIGITS > BCD_DIGITS) ? NUM_DIGITS : BCD_DIGITS;

    localparam int unsigned SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int unsigned BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned SCAN_CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_CW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned BIT_CW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SCAN_CW-1:0]  SCAN_LAST  = SCAN_CW'(SCAN_DIV - 1);
    localparam logic [BLINK_CW-1:0] BLINK_LAST = BLINK_CW'(BLINK_DIV - 1);
    localparam logic [BIT_CW-1:0]   BIT_LAST   = BIT_CW'(DATA_W - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Prescalers
    // ------------------------------------------------------------------
    logic [SCAN_CW-1:0]  scan_cnt;
    logic [BLINK_CW-1:0] blink_cnt;
    logic                blink_phase;
    logic                scan_tick;
    logic                blink_tick;

    always_comb begin
        scan_tick  = (scan_cnt == SCAN_LAST);
        blink_tick = (blink_cnt == BLINK_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
            if (blink_tick) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Binary-to-BCD conversion (shift-add-3, one bit per clock)
    // ------------------------------------------------------------------
    state_t             state;
    logic [DATA_W-1:0]  bin_sr;
    logic [BCD_W-1:0]   bcd_acc;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   display;
    logic [BIT_CW-1:0]  bit_cnt;
    logic               ovf_next;

    always_comb begin
        bcd_adj = bcd_acc;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Any nonzero nibble above the displayed digits means value >= 10^NUM_DIGITS.
    if (NUM_DIGITS < BCD_DIGITS) begin : g_ovf
        always_comb ovf_next = |bcd_acc[BCD_W-1:4*NUM_DIGITS];
    end else begin : g_no_ovf
        always_comb ovf_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            ovf     <= 1'b0;
            bin_sr  <= '0;
            bcd_acc <= '0;
            bit_cnt <= '0;
            display <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        bin_sr  <= bin_data;
                        bcd_acc <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_acc <= {bcd_adj[BCD_W-2:0], bin_sr[DATA_W-1]};
                    bin_sr  <= bin_sr << 1;
                    if (bit_cnt == BIT_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // load is deliberately not looked at here; busy is still high.
                    display <= bcd_acc;
                    ovf     <= ovf_next;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Digit scan and segment generation
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]        idx;
    logic [4*EXT_DIGITS-1:0] disp_ext;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_nib;
    logic [7:0]              seg_next;

    // Digits beyond the BCD accumulator width read as zero.
    always_comb begin
        disp_ext            = '0;
        disp_ext[BCD_W-1:0] = display;
    end

    // lz_blank[k]: nibbles k..NUM_DIGITS-1 all zero; digit 0 is never blanked.
    always_comb begin
        logic        run;
        int unsigned k;
        run      = 1'b1;
        k        = 0;
        lz_blank = '0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            k           = NUM_DIGITS - 1 - j;
            run         = run & (disp_ext[4*k +: 4] == 4'd0);
            lz_blank[k] = run;
        end
        lz_blank[0] = 1'b0;
    end

    always_comb begin
        cur_nib  = disp_ext[4*idx +: 4];
        seg_next = seg_code(cur_nib);
        if (blank_lz && lz_blank[idx]) begin
            seg_next = 8'hFF;
        end
        if (ovf) begin
            seg_next = 8'hBF;
        end
        if (dp_mask[idx]) begin
            seg_next[7] = 1'b0;
        end
        if (blink_phase && blink_mask[idx]) begin
            seg_next = 8'hFF;
        end
    end

    // Outputs present the current index on the tick edge, while idx advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            fnd_data <= 8'hFF;
            fnd_com  <= '1;
        end else if (scan_tick) begin
            fnd_data <= seg_next;
            fnd_com  <= ~(NUM_DIGITS'(1) << idx);
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: scaled clocks (10 clks per digit,
// blink toggles every 50 clks), table-driven conversions with a scoreboard,
// and hand-written sequences for reset, load collisions, blink and a
// 6-digit instance.
module tb_fnd_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] bin_data = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  blink_mask = '0;
    logic        blank_lz = 1'b0;
    logic        busy, ovf;
    logic [7:0]  fnd_data;
    logic [3:0]  fnd_com;

    logic        busy6, ovf6;
    logic [7:0]  fnd_data6;
    logic [5:0]  fnd_com6;

    int n_vec = 0;
    int n_fail = 0;
    int unsigned cyc = 0;

    fnd_scan_ctrl #(
        .NUM_DIGITS(4), .DATA_W(14), .CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(10)
    ) dut (
        .clk(clk), .reset(reset), .bin_data(bin_data), .load(load), .busy(busy),
        .dp_mask(dp_mask), .blink_mask(blink_mask), .blank_lz(blank_lz),
        .ovf(ovf), .fnd_data(fnd_data), .fnd_com(fnd_com)
    );

    fnd_scan_ctrl #(
        .NUM_DIGITS(6), .DATA_W(14), .CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(10)
    ) dut6 (
        .clk(clk), .reset(reset), .bin_data(14'd0), .load(1'b0), .busy(busy6),
        .dp_mask(6'd0), .blink_mask(6'd0), .blank_lz(1'b0),
        .ovf(ovf6), .fnd_data(fnd_data6), .fnd_com(fnd_com6)
    );

    always #5 clk = ~clk;

    // Edges since reset release.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        int unsigned     value;
        logic            lz;
        logic [3:0]      dp;
        logic            exp_ovf;
        logic [3:0][7:0] seg;     // seg[k] = expected code of digit k
    } vec_t;

    vec_t vecs[14];
    vec_t sb[$];

    function automatic vec_t mk(input int unsigned value, input logic lz, input logic [3:0] dp,
                                input logic o, input logic [31:0] segs);
        vec_t v;
        v.value   = value;
        v.lz      = lz;
        v.dp      = dp;
        v.exp_ovf = o;
        v.seg     = segs;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int com_idx(input logic [3:0] c);
        int r;
        int zeros;
        r = -1;
        zeros = 0;
        for (int i = 0; i < 4; i++) begin
            if (c[i] === 1'b0) begin
                zeros++;
                r = i;
            end
        end
        return (zeros == 1) ? r : -1;
    endfunction

    task automatic wait_update(output bit ok);
        logic [3:0] prev;
        prev = fnd_com;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (fnd_com !== prev) ok = 1'b1;
        end
    endtask

    task automatic wait_update6(output bit ok);
        logic [5:0] prev;
        prev = fnd_com6;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (fnd_com6 !== prev) ok = 1'b1;
        end
    endtask

    task automatic observe(input logic [3:0][7:0] seg, input int n);
        int prev;
        int idx;
        bit ok;
        prev = -1;
        for (int k = 0; k < n; k++) begin
            wait_update(ok);
            check("scan_timeout", 32'(ok), 32'd1);
            idx = com_idx(fnd_com);
            check("com_onehot", 32'(idx >= 0), 32'd1);
            if (prev >= 0) check("scan_order", 32'(idx), 32'((prev + 1) % 4));
            if (idx >= 0) check($sformatf("seg_d%0d", idx), 32'(fnd_data), 32'(seg[idx]));
            prev = idx;
        end
    endtask

    // Load v; optionally drive a second load when the busy sample count hits inj_at.
    task automatic run_vec(input vec_t v, input int inj_at, input logic [13:0] inj_val);
        vec_t e;
        int   cnt;
        blank_lz = v.lz;
        dp_mask  = v.dp;
        bin_data = v.value[13:0];
        load     = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        load = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (inj_at != 0 && cnt == inj_at) begin
                bin_data = inj_val;
                load     = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
        end
        check("busy_cycles", 32'(cnt), 32'd15);
        e = sb.pop_front();
        check("ovf", 32'(ovf), 32'(e.exp_ovf));
        @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
        observe(e.seg, 8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
        $fatal(1);
    end

    initial begin
        bit          ok;
        logic [5:0]  exp6;
        logic [7:0]  exp;
        logic [3:0][7:0] segs;
        int          idx;
        int unsigned phase;
        bit          on_seen, off_seen;

        vecs[0]  = mk(1234,  1'b0, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99});
        vecs[1]  = mk(7,     1'b1, 4'b0000, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hF8});
        vecs[2]  = mk(0,     1'b1, 4'b0000, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hC0});
        vecs[3]  = mk(5,     1'b1, 4'b0100, 1'b0, {8'hFF, 8'h7F, 8'hFF, 8'h92});
        vecs[4]  = mk(12000, 1'b0, 4'b0000, 1'b1, {8'hBF, 8'hBF, 8'hBF, 8'hBF});
        vecs[5]  = mk(9999,  1'b0, 4'b0000, 1'b0, {8'h90, 8'h90, 8'h90, 8'h90});
        vecs[6]  = mk(0,     1'b0, 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0});
        vecs[7]  = mk(16383, 1'b0, 4'b1001, 1'b1, {8'h3F, 8'hBF, 8'hBF, 8'h3F});
        vecs[8]  = mk(10000, 1'b1, 4'b0000, 1'b1, {8'hBF, 8'hBF, 8'hBF, 8'hBF});
        vecs[9]  = mk(305,   1'b1, 4'b0001, 1'b0, {8'hFF, 8'hB0, 8'hC0, 8'h12});
        vecs[10] = mk(1000,  1'b1, 4'b0000, 1'b0, {8'hF9, 8'hC0, 8'hC0, 8'hC0});
        vecs[11] = mk(80,    1'b1, 4'b1000, 1'b0, {8'h7F, 8'hFF, 8'h80, 8'hC0});
        vecs[12] = mk(9,     1'b1, 4'b1111, 1'b0, {8'h7F, 8'h7F, 8'h7F, 8'h10});
        vecs[13] = mk(10,    1'b1, 4'b0000, 1'b0, {8'hFF, 8'hFF, 8'hF9, 8'hC0});

        // Reset held 3 clocks.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_com", 32'(fnd_com), 32'h0F);
        check("reset_data", 32'(fnd_data), 32'hFF);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_com6", 32'(fnd_com6), 32'h3F);
        reset = 1'b0;

        wait_update(ok);
        check("first_tick_seen", 32'(ok), 32'd1);
        check("first_tick_cycle", cyc, 32'd10);
        check("first_com", 32'(fnd_com), 32'b1110);
        check("first_data", 32'(fnd_data), 32'hC0);
        check("first_com6", 32'(fnd_com6), 32'b111110);
        check("first_data6", 32'(fnd_data6), 32'hC0);

        // Six-digit instance: index wraps 5 -> 0.
        for (int k = 1; k <= 6; k++) begin
            wait_update6(ok);
            check("scan6_timeout", 32'(ok), 32'd1);
            exp6 = ~(6'b000001 << (k % 6));
            check("scan6_com", 32'(fnd_com6), 32'(exp6));
            check("scan6_data", 32'(fnd_data6), 32'hC0);
        end

        // Table-driven conversions.
        for (int i = 0; i < 14; i++) run_vec(vecs[i], 0, 14'd0);

        // Load while busy is ignored.
        run_vec(mk(4321, 1'b0, 4'b0000, 1'b0, {8'h99, 8'hB0, 8'hA4, 8'hF9}), 3, 14'd55);

        // Load during the DONE cycle is ignored as well.
        run_vec(mk(2468, 1'b0, 4'b0000, 1'b0, {8'hA4, 8'h99, 8'h82, 8'h80}), 15, 14'd1111);

        // Blink on digit 0 only.
        segs = {8'hF9, 8'hA4, 8'hB0, 8'h99};
        run_vec(mk(1234, 1'b0, 4'b0000, 1'b0, segs), 0, 14'd0);
        blink_mask = 4'b0001;
        on_seen  = 1'b0;
        off_seen = 1'b0;
        for (int k = 0; k < 24; k++) begin
            wait_update(ok);
            check("blink_timeout", 32'(ok), 32'd1);
            idx   = com_idx(fnd_com);
            phase = ((cyc - 1) / 50) % 2;
            if (idx == 0) begin
                exp = (phase == 1) ? 8'hFF : segs[0];
                if (phase == 1) off_seen = 1'b1;
                else            on_seen  = 1'b1;
            end else if (idx > 0) begin
                exp = segs[idx];
            end else begin
                exp = 8'hXX;
            end
            check("blink_com_onehot", 32'(idx >= 0), 32'd1);
            if (idx >= 0) check($sformatf("blink_seg_d%0d", idx), 32'(fnd_data), 32'(exp));
        end
        check("blink_both_phases", 32'(on_seen && off_seen), 32'd1);
        blink_mask = 4'b0000;

        // Reset mid-conversion aborts it and clears the display.
        run_vec(vecs[5], 0, 14'd0);
        blank_lz = 1'b0;
        dp_mask  = 4'b0000;
        bin_data = 14'd1234;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_mid", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_com", 32'(fnd_com), 32'h0F);
        check("abort_data", 32'(fnd_data), 32'hFF);
        reset = 1'b0;
        observe({8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
